// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared widths, default depth and operand type for the barrel shifter feed path
package barrel_pkg;

  localparam int DATA_W        = 8;
  localparam int AMT_W         = 3;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } operand_t;

endpackage

// File: rtl/barrel_fifo_mem.sv
// rtl/barrel_fifo_mem.sv - operand storage array, one synchronous write port, one asynchronous read port
module barrel_fifo_mem
  import barrel_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  operand_t      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output operand_t      rdata_o
);

  // No reset: the controller masks the read data whenever the FIFO is empty.
  operand_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/barrel_feed_fifo.sv
// rtl/barrel_feed_fifo.sv - show-ahead operand FIFO presenting the oldest {data, amt} pair on d/c
module barrel_feed_fifo
  import barrel_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d,
  output logic [AMT_W-1:0]  c,
  output logic [AW:0]       count
);

  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  operand_t      wr_entry, head;

  // Readiness ignores out_ready so a full FIFO never pushes into a slot being popped.
  assign in_ready  = !rst && (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry.data = in_data;
  assign wr_entry.amt  = in_amt;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  barrel_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign d     = out_valid ? head.data : '0;
  assign c     = out_valid ? head.amt  : '0;
  assign count = count_q;

endmodule

// File: tb/tb_barrel_feed_fifo.sv
// tb/tb_barrel_feed_fifo.sv - directed self-checking bench for barrel_feed_fifo
module tb_barrel_feed_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic [2:0] c;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  barrel_feed_fifo #(
    .DEPTH (4),
    .AW    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .c         (c),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] dat, input logic [2:0] amt);
    in_valid = 1'b1;
    in_data  = dat;
    in_amt   = amt;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_c", c, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // three pushes, no pops
    push(8'hA5, 3'd1);
    chk("first_lat_valid", out_valid, 1);
    push(8'h3C, 3'd2);
    push(8'hFF, 3'd7);
    chk("fill3_count", count, 3);
    chk("fill3_d", d, 8'hA5);
    chk("fill3_c", c, 1);
    chk("fill3_in_ready", in_ready, 1);

    // full: pushes ignored, including on a popping edge
    push(8'h44, 3'd5);
    chk("full_count", count, 4);
    in_valid = 1'b1; in_data = 8'h11; in_amt = 3'd0;
    #1;
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_hold_count", count, 4);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_pop_count", count, 3);
    chk("full_pop_d", d, 8'h3C);
    chk("full_pop_c", c, 2);
    tick();
    out_ready = 1'b0;
    chk("two_count", count, 2);
    chk("two_d", d, 8'hFF);

    // simultaneous push and pop
    in_valid = 1'b1; in_data = 8'h22; in_amt = 3'd4; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_count", count, 2);
    chk("pp_d", d, 8'h44);
    chk("pp_c", c, 5);
    tick();
    chk("drain_d", d, 8'h22);
    chk("drain_c", c, 4);
    chk("drain_count", count, 1);
    tick();
    chk("empty_count", count, 0);
    chk("empty_valid", out_valid, 0);

    // pop on empty is ignored
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("uf_count", count, 0);
      chk("uf_d", d, 0);
      chk("uf_c", c, 0);
    end

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_amt = 3'(i % 8);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_d", d, i);
      chk("stream_c", c, i % 8);
      chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_count", count, 0);
    out_ready = 1'b0;

    // reset beats a concurrent push and discards held entries
    push(8'h01, 3'd1);
    push(8'h02, 3'd2);
    push(8'h03, 3'd3);
    chk("pre_rst_count", count, 3);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_amt = 3'd3;
    #1;
    chk("rst_in_ready_live", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("post_rst_count", count, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_d", d, 0);
    chk("post_rst_c", c, 0);
    tick();
    chk("post_rst_dropped", count, 0);
    push(8'h5A, 3'd6);
    chk("post_rst_push_d", d, 8'h5A);
    chk("post_rst_push_c", c, 6);
    chk("post_rst_push_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
